// File: rtl/mem_copy_pkg.sv
// Shared types and default sizes for the block-copy sequencer.
// Sub-module mem_copy_addr_gen is sensitive to the MEMCOPY_OVERLAP_EN macro.
package mem_copy_pkg;

  localparam int unsigned DM_ADDRESS_DEF = 9;
  localparam int unsigned DATA_W_DEF     = 32;
  localparam int unsigned LEN_W_DEF      = 10;

  typedef enum logic [1:0] {
    StIdle,
    StRd,
    StWr,
    StDone
  } mem_copy_state_t;

endpackage

// File: rtl/mem_copy_ctrl_if.sv
// Command and data-memory port bundle of mem_copy_ctrl.
// slave is the sequencer side, master is the control-unit/memory side.
interface mem_copy_ctrl_if
  import mem_copy_pkg::*;
#(
  parameter int unsigned DM_ADDRESS = DM_ADDRESS_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned LEN_W      = LEN_W_DEF
) ();

  logic                  start;
  logic [DM_ADDRESS-1:0] src;
  logic [DM_ADDRESS-1:0] dst;
  logic [LEN_W-1:0]      len;
  logic                  busy;
  logic                  done;
  logic                  stall_cpu;
  logic                  cp_rd_en;
  logic [DM_ADDRESS-1:0] cp_rd_addr;
  logic [DATA_W-1:0]     cp_rd_data;
  logic                  cp_wr_en;
  logic [DM_ADDRESS-1:0] cp_wr_addr;
  logic [DATA_W-1:0]     cp_wr_data;

  modport slave (
    input  start, src, dst, len, cp_rd_data,
    output busy, done, stall_cpu, cp_rd_en, cp_rd_addr, cp_wr_en, cp_wr_addr, cp_wr_data
  );

  modport master (
    output start, src, dst, len, cp_rd_data,
    input  busy, done, stall_cpu, cp_rd_en, cp_rd_addr, cp_wr_en, cp_wr_addr, cp_wr_data
  );

endinterface

// File: rtl/mem_copy_addr_gen.sv
// Source/destination pointer pair for the block copy; direction chosen at launch.
// MEMCOPY_OVERLAP_EN adds descending (memmove) copies for forward-overlapping ranges.
module mem_copy_addr_gen
  import mem_copy_pkg::*;
#(
  parameter int unsigned DM_ADDRESS = DM_ADDRESS_DEF,
  parameter int unsigned LEN_W      = LEN_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  launch,
  input  logic                  step,
  input  logic [DM_ADDRESS-1:0] src,
  input  logic [DM_ADDRESS-1:0] dst,
  input  logic [LEN_W-1:0]      len,
  output logic [DM_ADDRESS-1:0] src_cur,
  output logic [DM_ADDRESS-1:0] dst_cur
);

  logic [DM_ADDRESS-1:0] src_q;
  logic [DM_ADDRESS-1:0] dst_q;

`ifdef MEMCOPY_OVERLAP_EN
  logic                  desc_q;
  logic                  desc_d;
  logic [DM_ADDRESS-1:0] diff;
  logic [DM_ADDRESS-1:0] len_dec;

  // Destination starts inside the source window: copy from the top down.
  assign diff    = dst - src;
  assign desc_d  = (dst > src) && ({{(LEN_W - DM_ADDRESS){1'b0}}, diff} < len);
  assign len_dec = DM_ADDRESS'(len - LEN_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      desc_q <= 1'b0;
      src_q  <= '0;
      dst_q  <= '0;
    end else if (launch) begin
      desc_q <= desc_d;
      src_q  <= desc_d ? src + len_dec : src;
      dst_q  <= desc_d ? dst + len_dec : dst;
    end else if (step) begin
      src_q <= desc_q ? src_q - DM_ADDRESS'(1) : src_q + DM_ADDRESS'(1);
      dst_q <= desc_q ? dst_q - DM_ADDRESS'(1) : dst_q + DM_ADDRESS'(1);
    end
  end
`else
  logic unused_len;
  assign unused_len = ^len;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q <= '0;
      dst_q <= '0;
    end else if (launch) begin
      src_q <= src;
      dst_q <= dst;
    end else if (step) begin
      src_q <= src_q + DM_ADDRESS'(1);
      dst_q <= dst_q + DM_ADDRESS'(1);
    end
  end
`endif

  assign src_cur = src_q;
  assign dst_cur = dst_q;

endmodule

// File: rtl/mem_copy_ctrl.sv
// Multi-word block-copy sequencer: one word per RD/WR pair via a buffer register.
// Overlap-safe (memmove) direction selection is compiled in with MEMCOPY_OVERLAP_EN.
module mem_copy_ctrl
  import mem_copy_pkg::*;
#(
  parameter int unsigned DM_ADDRESS = DM_ADDRESS_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned LEN_W      = LEN_W_DEF
) (
  input logic            clk,
  input logic            rst_n,
  mem_copy_ctrl_if.slave bus
);

  mem_copy_state_t       state_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  rd_en_q;
  logic                  wr_en_q;
  logic [LEN_W-1:0]      remaining_q;
  logic [DATA_W-1:0]     buf_q;
  logic                  launch;
  logic                  step;
  logic [DM_ADDRESS-1:0] src_cur;
  logic [DM_ADDRESS-1:0] dst_cur;

  assign launch = (state_q == StIdle) && bus.start;
  assign step   = (state_q == StWr);

  mem_copy_addr_gen #(
    .DM_ADDRESS(DM_ADDRESS),
    .LEN_W     (LEN_W)
  ) u_addr_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .launch (launch),
    .step   (step),
    .src    (bus.src),
    .dst    (bus.dst),
    .len    (bus.len),
    .src_cur(src_cur),
    .dst_cur(dst_cur)
  );

  // Output flags are registered alongside the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      remaining_q <= '0;
      buf_q       <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            remaining_q <= bus.len;
            busy_q      <= 1'b1;
            if (bus.len == '0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StRd;
              rd_en_q <= 1'b1;
            end
          end
        end
        StRd: begin
          buf_q   <= bus.cp_rd_data;
          rd_en_q <= 1'b0;
          wr_en_q <= 1'b1;
          state_q <= StWr;
        end
        StWr: begin
          wr_en_q     <= 1'b0;
          remaining_q <= remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end else begin
            state_q <= StRd;
            rd_en_q <= 1'b1;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          rd_en_q <= 1'b0;
          wr_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.stall_cpu  = busy_q;
  assign bus.cp_rd_en   = rd_en_q;
  assign bus.cp_rd_addr = src_cur;
  assign bus.cp_wr_en   = wr_en_q;
  assign bus.cp_wr_addr = dst_cur;
  assign bus.cp_wr_data = buf_q;

endmodule

// File: tb/tb_mem_copy_ctrl.sv
// Scoreboard bench for mem_copy_ctrl: a word-level copy model predicts every write,
// the busy length of each copy and the final memory image.
module tb_mem_copy_ctrl;
  import mem_copy_pkg::*;

  localparam int unsigned AW    = DM_ADDRESS_DEF;
  localparam int unsigned DW    = DATA_W_DEF;
  localparam int unsigned LW    = LEN_W_DEF;
  localparam int          DEPTH = 1 << AW;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mem_copy_ctrl_if #(.DM_ADDRESS(AW), .DATA_W(DW), .LEN_W(LW)) bus ();

  mem_copy_ctrl #(.DM_ADDRESS(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [DW-1:0] mem     [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  logic          load = 1'b0;

  assign bus.cp_rd_data = mem[bus.cp_rd_addr];

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= ref_mem[i];
    end else if (bus.cp_wr_en) begin
      mem[bus.cp_wr_addr] <= bus.cp_wr_data;
    end
  end

  int            tests = 0;
  int            fails = 0;
  int            exp_addr[$];
  logic [DW-1:0] exp_data[$];
  int            exp_busy[$];
  int            busy_cnt = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT writes or signals done.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt = 0;
    end else begin
      if (bus.cp_rd_en || bus.cp_wr_en) check("rd_wr_exclusive", bus.cp_rd_en & bus.cp_wr_en, 0);
      if (bus.busy || bus.stall_cpu) check("stall_eq_busy", bus.stall_cpu, bus.busy);
      if (bus.cp_wr_en) begin
        check("write_expected", 64'(exp_addr.size() != 0), 1);
        if (exp_addr.size() != 0) begin
          check("wr_addr", bus.cp_wr_addr, exp_addr.pop_front());
          check("wr_data", bus.cp_wr_data, exp_data.pop_front());
        end
      end
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        check("done_expected", 64'(exp_busy.size() != 0), 1);
        if (exp_busy.size() != 0) check("busy_cycles", busy_cnt, exp_busy.pop_front());
        busy_cnt = 0;
      end
    end
  end

  // Reference copy: memcpy word by word, or memmove when overlap handling is built in.
  task automatic model(input int s, input int d, input int l, input int nmax, input bit push_busy);
    bit desc = 1'b0;
`ifdef MEMCOPY_OVERLAP_EN
    desc = (d > s) && ((d - s) < l);
`endif
    for (int k = 0; k < l && k < nmax; k++) begin
      int i  = desc ? (l - 1 - k) : k;
      int sa = (s + i) % DEPTH;
      int da = (d + i) % DEPTH;
      ref_mem[da] = ref_mem[sa];
      exp_addr.push_back(da);
      exp_data.push_back(ref_mem[sa]);
    end
    if (push_busy) exp_busy.push_back(2 * l + 1);
  endtask

  task automatic load_mem();
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic scramble();
    bus.src = AW'($urandom);
    bus.dst = AW'($urandom);
    bus.len = LW'($urandom);
  endtask

  task automatic launch(input int s, input int d, input int l);
    bus.start = 1'b1;
    bus.src   = AW'(s);
    bus.dst   = AW'(d);
    bus.len   = LW'(l);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    scramble();
  endtask

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    check("done_seen", seen, 1);
    @(negedge clk);
  endtask

  task automatic check_mem();
    int diffs = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) diffs++;
    check("mem_image", diffs, 0);
  endtask

  task automatic run(input int s, input int d, input int l);
    model(s, d, l, 1 << 20, 1'b1);
    launch(s, d, l);
    wait_done(2 * l + 8);
    check_mem();
  endtask

  task automatic check_zero();
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_stall", bus.stall_cpu, 0);
    check("rst_rd_en", bus.cp_rd_en, 0);
    check("rst_wr_en", bus.cp_wr_en, 0);
    check("rst_rd_addr", bus.cp_rd_addr, 0);
    check("rst_wr_addr", bus.cp_wr_addr, 0);
    check("rst_wr_data", bus.cp_wr_data, 0);
  endtask

  initial begin
    logic [DW-1:0] v [4];
    bit            seen;
    v[0] = 32'hA1A1_0001;
    v[1] = 32'hB2B2_0002;
    v[2] = 32'hC3C3_0003;
    v[3] = 32'hD4D4_0004;
    bus.start = 1'b0;
    bus.src   = '0;
    bus.dst   = '0;
    bus.len   = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = DW'($urandom);
    #2 rst_n = 1'b0;
    #1 check_zero();
    @(negedge clk);
    load_mem();
    rst_n = 1'b1;
    @(negedge clk);

    // Plain ascending copy.
    for (int i = 0; i < 4; i++) ref_mem['h10 + i] = v[i];
    load_mem();
    run('h010, 'h100, 4);
    for (int i = 0; i < 4; i++) check("basic_dst", mem['h100 + i], v[i]);

    // Zero length.
    run('h055, 'h155, 0);

    // Source wraps past the top of memory.
    ref_mem['h1FE] = v[0];
    ref_mem['h1FF] = v[1];
    ref_mem['h000] = v[2];
    ref_mem['h001] = v[3];
    load_mem();
    run('h1FE, 'h020, 4);
    for (int i = 0; i < 4; i++) check("wrap_dst", mem['h20 + i], v[i]);

    // Forward overlap by one word.
    for (int i = 0; i < 3; i++) ref_mem['h40 + i] = v[i];
    load_mem();
    run('h040, 'h041, 3);
`ifdef MEMCOPY_OVERLAP_EN
    for (int i = 0; i < 3; i++) check("overlap_dst", mem['h41 + i], v[i]);
`else
    for (int i = 0; i < 3; i++) check("overlap_dst", mem['h41 + i], v[0]);
`endif

    // Full overlap leaves memory unchanged.
    run('h0A0, 'h0A0, 5);

    // A second start issued during WR must be ignored.
    model('h030, 'h130, 4, 1 << 20, 1'b1);
    launch('h030, 'h130, 4);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.src   = AW'('h000);
    bus.dst   = AW'('h1F0);
    bus.len   = LW'(5);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(20);
    check_mem();

    // Reset in the 3rd WR of an 8-word copy: only two words land.
    model('h080, 'h180, 8, 2, 1'b0);
    launch('h080, 'h180, 8);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero();
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_mem();
    run('h080, 'h180, 8);

    // Held start relaunches after one IDLE cycle.
    model('h060, 'h160, 3, 1 << 20, 1'b1);
    model('h070, 'h170, 2, 1 << 20, 1'b1);
    bus.start = 1'b1;
    bus.src   = AW'('h060);
    bus.dst   = AW'('h160);
    bus.len   = LW'(3);
    @(posedge clk);
    #1;
    bus.src = AW'('h070);
    bus.dst = AW'('h170);
    bus.len = LW'(2);
    seen    = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    check("b2b_first_done", seen, 1);
    @(negedge clk);
    check("b2b_idle_gap", bus.busy, 0);
    @(negedge clk);
    check("b2b_relaunch", bus.busy, 1);
    bus.start = 1'b0;
    scramble();
    wait_done(20);
    check_mem();

    // Random copies, biased toward nearby (overlapping) ranges.
    for (int t = 0; t < 30; t++) begin
      int s = $urandom_range(0, DEPTH - 1);
      int d = ($urandom_range(0, 1) == 1) ? (s + $urandom_range(0, 6) - 3 + DEPTH) % DEPTH
                                          : $urandom_range(0, DEPTH - 1);
      int l = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 12);
      run(s, d, l);
    end

    check("writes_left", exp_addr.size(), 0);
    check("dones_left", exp_busy.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
